fpu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single `FPU_32bit` instance among `N_REQ` requesters. It accepts one operation at a time from the requester side, issues a one-cycle start pulse to the FPU, waits for the FPU's done pulse, and routes the result and flags back to the originating requester. It sits between the FPU and its clients (e.g. integer-core FP issue port, DMA-driven vector loop).

---
 rtl/fpu_arb_pkg.sv | 14 +
 rtl/fpu_arbiter_rr.sv | 19 +
 rtl/fpu_arbiter.sv | 142 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared encodings for the FPU arbiter (modes, FSM states, flag bit positions)
package fpu_arb_pkg;
  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  localparam int FLG_ZERO = 0;
  localparam int FLG_NAN  = 1;
  localparam int FLG_INF  = 2;
  localparam int FLG_ERR  = 3;
  localparam int FLG_TO   = 4;
  localparam logic [31:0] FPU_QNAN = 32'h7FC00000;
endpackage

// File: rtl/fpu_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, search starts at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  logic [N-1:0] one_hot;
  // scan offsets from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    grant = '0;
    one_hot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      one_hot = N'(1) << ((int'(ptr) + i) % N);
      grant = ((req & one_hot) != '0) ? one_hot : grant;
    end
  end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU among N_REQ requesters; optional watchdog via FPU_ARB_TIMEOUT_EN
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [2*N_REQ-1:0]   req_mode,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 fpu_start,
  output logic [1:0]           fpu_mode,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  input  logic                 fpu_ready,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_s,
  input  logic                 fpu_zero,
  input  logic                 fpu_nan,
  input  logic                 fpu_inf,
  input  logic                 fpu_error
);
  localparam int PW = $clog2(N_REQ);
  arb_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, gsel;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] mode_q, mode_d;
  logic [4:0] flg_q, flg_d;
  logic [N_REQ-1:0] grant;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // index of the one-hot grant, used to select operands and remember the owner
  always_comb begin
    gsel = '0;
    for (int i = 0; i < N_REQ; i++) gsel = grant[i] ? PW'(i) : gsel;
  end

  // state, pointer, holding and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // next state: grant in IDLE, single issue, wait for done (or watchdog), respond
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    res_d   = res_q;
    flg_d   = flg_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d   = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
`endif
    case (state_q)
      IDLE: if (fpu_ready && (req_valid != '0)) begin
        state_d = ISSUE;
        g_d     = gsel;
        a_d     = req_a[32*int'(gsel) +: 32];
        b_d     = req_b[32*int'(gsel) +: 32];
        mode_d  = req_mode[2*int'(gsel) +: 2];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (fpu_done) begin
        state_d          = RESP;
        res_d            = fpu_s;
        flg_d            = '0;
        flg_d[FLG_ZERO]  = fpu_zero;
        flg_d[FLG_NAN]   = fpu_nan;
        flg_d[FLG_INF]   = fpu_inf;
        flg_d[FLG_ERR]   = fpu_error;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d         = RESP;
        res_d           = FPU_QNAN;
        flg_d           = '0;
        flg_d[FLG_TO]   = 1'b1;
        flg_d[FLG_ERR]  = 1'b1;
      end
`endif
      RESP: begin
        state_d = IDLE;
        ptr_d   = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: accept pulse is combinational so a grant lands in the cycle fpu_ready rises
  always_comb begin
    req_ready  = (state_q == IDLE && fpu_ready) ? grant : '0;
    rsp_valid  = (state_q == RESP) ? (N_REQ'(1) << g_q) : '0;
    rsp_result = res_q;
    rsp_flags  = flg_q;
    fpu_start  = (state_q == ISSUE);
    fpu_a      = a_q;
    fpu_b      = b_q;
    fpu_mode   = mode_q;
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed checks of grant order, routing, stalls, stray done and reset
module tb_fpu_arbiter;
  import fpu_arb_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [2*N-1:0] req_mode = '0;
  logic [31:0] rsp_result, fpu_a, fpu_b, fpu_s = '0;
  logic [4:0] rsp_flags;
  logic [1:0] fpu_mode;
  logic fpu_start, fpu_ready = 1'b1, fpu_done = 1'b0;
  logic fpu_zero = 1'b0, fpu_nan = 1'b0, fpu_inf = 1'b0, fpu_error = 1'b0;
  int checks = 0, failures = 0, cyc = 0, starts = 0;
  int m_cnt = 0, m_lat = 2;
  logic m_en = 1'b1;
  logic [31:0] m_res = '0;

  always #5 clk = ~clk;

  fpu_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .fpu_start(fpu_start),
    .fpu_mode(fpu_mode), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ready(fpu_ready),
    .fpu_done(fpu_done), .fpu_s(fpu_s), .fpu_zero(fpu_zero), .fpu_nan(fpu_nan),
    .fpu_inf(fpu_inf), .fpu_error(fpu_error)
  );

  function automatic logic [31:0] fp_ref(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case ({m, a, b})
      {FPU_ADD, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {FPU_ADD, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {FPU_SUB, 32'h40A00000, 32'h3F800000}: return 32'h40800000;
      {FPU_SUB, 32'h3F800000, 32'h3F800000}: return 32'h00000000;
      {FPU_MUL, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {FPU_DIV, 32'h41200000, 32'h40000000}: return 32'h40A00000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    fpu_done = 1'b0;
    if (!rst_n) m_cnt = 0;
    else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          fpu_done = 1'b1;
          fpu_s = m_res;
          fpu_zero = (m_res == 32'h0);
        end
      end
      if (fpu_start && m_en) begin
        m_cnt = m_lat;
        m_res = fp_ref(fpu_mode, fpu_a, fpu_b);
      end
    end
    if (fpu_start) starts++;
    cyc++;
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_mode[2*i +: 2] = m;
  endtask

  task automatic wait_rsp(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit && k < 0; i++) begin
      tick();
      if (rsp_valid != '0) k = i;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_flags !== 5'b0) begin failures++; $display("FAIL reset_rsp_flags got=%b exp=00000", rsp_flags); end
    checks++; if (fpu_start !== 1'b0) begin failures++; $display("FAIL reset_fpu_start got=%b exp=0", fpu_start); end
    checks++; if (fpu_a !== 32'h0) begin failures++; $display("FAIL reset_fpu_a got=%h exp=0", fpu_a); end
    checks++; if (fpu_b !== 32'h0) begin failures++; $display("FAIL reset_fpu_b got=%h exp=0", fpu_b); end
    checks++; if (fpu_mode !== 2'b0) begin failures++; $display("FAIL reset_fpu_mode got=%b exp=00", fpu_mode); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int k, s0;
    m_lat = 3;
    set_op(0, 32'h3F800000, 32'h40000000, FPU_ADD);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_accept got=%b exp=0001", req_ready); end
    s0 = starts;
    tick();
    req_valid = '0;
    #1;
    checks++; if (fpu_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", fpu_start); end
    checks++; if (fpu_a !== 32'h3F800000) begin failures++; $display("FAIL single_fpu_a got=%h exp=3f800000", fpu_a); end
    checks++; if (fpu_b !== 32'h40000000) begin failures++; $display("FAIL single_fpu_b got=%h exp=40000000", fpu_b); end
    checks++; if (fpu_mode !== FPU_ADD) begin failures++; $display("FAIL single_fpu_mode got=%b exp=00", fpu_mode); end
    wait_rsp(30, k);
    checks++; if (k !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", k); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_result !== 32'h40400000) begin failures++; $display("FAIL single_result got=%h exp=40400000", rsp_result); end
    checks++; if (rsp_flags !== 5'b0) begin failures++; $display("FAIL single_flags got=%b exp=00000", rsp_flags); end
    checks++; if (starts - s0 !== 1) begin failures++; $display("FAIL single_start_count got=%0d exp=1", starts - s0); end
    tick();
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL single_rsp_pulse got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_result !== 32'h40400000) begin failures++; $display("FAIL single_result_hold got=%h exp=40400000", rsp_result); end
  endtask

  task automatic test_flags();
    int k;
    m_lat = 1;
    set_op(1, 32'h3F800000, 32'h3F800000, FPU_SUB);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL flags_accept got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(30, k);
    checks++; if (k !== 2) begin failures++; $display("FAIL flags_latency got=%0d exp=2", k); end
    checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL flags_rsp_valid got=%b exp=0010", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("FAIL flags_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_flags !== 5'b00001) begin failures++; $display("FAIL flags_zero got=%b exp=00001", rsp_flags); end
    tick();
  endtask

  task automatic test_fairness();
    logic [31:0] exp_res [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h40A00000};
    int gi = 0, ri = 0, last = 0;
    do_reset();
    m_lat = 2;
    set_op(0, 32'h3F800000, 32'h3F800000, FPU_ADD);
    set_op(1, 32'h40A00000, 32'h3F800000, FPU_SUB);
    set_op(2, 32'h40000000, 32'h40400000, FPU_MUL);
    set_op(3, 32'h41200000, 32'h40000000, FPU_DIV);
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 200 && ri < 8; c++) begin
      if (req_ready != '0) begin
        checks++; if (req_ready !== (4'b0001 << (gi % 4))) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", gi, req_ready, 4'b0001 << (gi % 4)); end
        if (gi > 0) begin
          checks++; if (cyc - last !== 5) begin failures++; $display("FAIL fair_gap%0d got=%0d exp=5", gi, cyc - last); end
        end
        last = cyc;
        gi++;
      end
      if (rsp_valid != '0) begin
        checks++; if (rsp_valid !== (4'b0001 << (ri % 4))) begin failures++; $display("FAIL fair_rsp%0d got=%b exp=%b", ri, rsp_valid, 4'b0001 << (ri % 4)); end
        checks++; if (rsp_result !== exp_res[ri % 4]) begin failures++; $display("FAIL fair_result%0d got=%h exp=%h", ri, rsp_result, exp_res[ri % 4]); end
        checks++; if (rsp_flags !== 5'b0) begin failures++; $display("FAIL fair_flags%0d got=%b exp=00000", ri, rsp_flags); end
        ri++;
      end
      tick();
      if (gi == 8) req_valid = '0;
      #1;
    end
    checks++; if (gi !== 8) begin failures++; $display("FAIL fair_grant_count got=%0d exp=8", gi); end
    checks++; if (ri !== 8) begin failures++; $display("FAIL fair_rsp_count got=%0d exp=8", ri); end
  endtask

  task automatic test_stall();
    int k;
    fpu_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL stall_ready%0d got=%b exp=0000", c, req_ready); end
      checks++; if (fpu_start !== 1'b0) begin failures++; $display("FAIL stall_start%0d got=%b exp=0", c, fpu_start); end
      tick();
    end
    fpu_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_release got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (fpu_start !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", fpu_start); end
    wait_rsp(30, k);
    checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL stall_rsp got=%b exp=0010", rsp_valid); end
    checks++; if (rsp_result !== 32'h40800000) begin failures++; $display("FAIL stall_result got=%h exp=40800000", rsp_result); end
    tick();
  endtask

  task automatic test_stray_done();
    int k;
    fpu_done = 1'b1;
    fpu_s = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL stray_rsp%0d got=%b exp=0000", c, rsp_valid); end
    end
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stray_idle_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(30, k);
    checks++; if (rsp_result !== 32'h40800000) begin failures++; $display("FAIL stray_result got=%h exp=40800000", rsp_result); end
    tick();
  endtask

  task automatic test_reset_wait();
    int k;
    m_lat = 6;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rstw_grant_ptr got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (fpu_start !== 1'b0) begin failures++; $display("FAIL rstw_start got=%b exp=0", fpu_start); end
    checks++; if (fpu_a !== 32'h0) begin failures++; $display("FAIL rstw_fpu_a got=%h exp=0", fpu_a); end
    checks++; if (fpu_mode !== 2'b0) begin failures++; $display("FAIL rstw_fpu_mode got=%b exp=00", fpu_mode); end
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("FAIL rstw_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL rstw_rsp got=%b exp=0000", rsp_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    wait_rsp(20, k);
    checks++; if (k !== -1) begin failures++; $display("FAIL rstw_no_rsp got=%0d exp=-1", k); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstw_ptr_zero got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(30, k);
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL rstw_after_rsp got=%b exp=0001", rsp_valid); end
    tick();
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    m_en = 1'b0;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    #1;
    checks++; if (fpu_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", fpu_start); end
    wait_rsp(40, k);
    checks++; if (k !== 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", k); end
    checks++; if (rsp_result !== 32'h7FC00000) begin failures++; $display("FAIL to_result got=%h exp=7fc00000", rsp_result); end
    checks++; if (rsp_flags !== 5'b11000) begin failures++; $display("FAIL to_flags got=%b exp=11000", rsp_flags); end
    tick();
    fpu_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL to_stray%0d got=%b exp=0000", c, rsp_valid); end
    end
    m_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_fairness();
    test_stall();
    test_stray_done();
    test_reset_wait();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
